// File: rtl/div_sequencer.sv
// Control sequencer for an iterative divider: accepts an operand pair, loads it over a
// shared bus, runs the datapath for ITER cycles and returns quotient/remainder.
module div_sequencer #(
    parameter int WIDTH = 16,
    parameter int ITER  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] dp_data,
    output logic             dp_load_dividend,
    output logic             dp_load_divisor,
    output logic             dp_start,
    output logic             dp_enable,
    input  logic [WIDTH-1:0] dp_result,
    input  logic [WIDTH-1:0] dp_residue,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_DVD,
        LOAD_DVS,
        INIT,
        RUN,
        CAPTURE,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             req_ready_q, busy_q;
    logic [WIDTH-1:0] dp_data_q, dp_data_d;
    logic             ld_dvd_q, ld_dvs_q, start_q, enable_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    dvd_d   = dividend_in;
                    dvs_d   = divisor_in;
                    state_d = LOAD_DVD;
                end
            end
            LOAD_DVD: state_d = LOAD_DVS;
            LOAD_DVS: begin
                // A zero divisor never reaches the datapath; the result is fixed here.
                if (dvs_q == '0) begin
                    quot_d  = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = INIT;
                end
            end
            INIT: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) state_d = CAPTURE;
            end
            CAPTURE: begin
                quot_d  = dp_result;
                rem_d   = dp_residue;
                dbz_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // rsp_valid trails RESP entry by one cycle so results settle before being offered.
        rsp_valid_d = (state_q == RESP) && !(rsp_valid_q && rsp_ready);

        dp_data_d = '0;
        if (state_d == LOAD_DVD)      dp_data_d = dvd_d;
        else if (state_d == LOAD_DVS) dp_data_d = dvs_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            dp_data_q   <= '0;
            ld_dvd_q    <= 1'b0;
            ld_dvs_q    <= 1'b0;
            start_q     <= 1'b0;
            enable_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dbz_q       <= dbz_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= (state_d == IDLE);
            busy_q      <= (state_d != IDLE);
            dp_data_q   <= dp_data_d;
            ld_dvd_q    <= (state_d == LOAD_DVD);
            ld_dvs_q    <= (state_d == LOAD_DVS);
            start_q     <= (state_d == INIT);
            enable_q    <= (state_d == RUN);
        end
    end

    assign req_ready        = req_ready_q;
    assign busy             = busy_q;
    assign rsp_valid        = rsp_valid_q;
    assign quotient         = quot_q;
    assign remainder        = rem_q;
    assign div_by_zero      = dbz_q;
    assign dp_data          = dp_data_q;
    assign dp_load_dividend = ld_dvd_q;
    assign dp_load_divisor  = ld_dvs_q;
    assign dp_start         = start_q;
    assign dp_enable        = enable_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomised bench for div_sequencer with a behavioural divider datapath and an
// arithmetic reference for results, latency and strobe counts.
module tb_div_sequencer;

    localparam int WIDTH = 16;
    localparam int ITER  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] dividend_in;
    logic [WIDTH-1:0] divisor_in;
    logic [WIDTH-1:0] dp_data;
    logic             dp_load_dividend;
    logic             dp_load_divisor;
    logic             dp_start;
    logic             dp_enable;
    logic [WIDTH-1:0] dp_result;
    logic [WIDTH-1:0] dp_residue;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    int checks = 0;
    int passes = 0;

    logic [WIDTH-1:0] dpDvd = '0;
    logic [WIDTH-1:0] dpDvs = '0;
    int itCnt = 0;
    int enableTotal = 0;
    int startTotal = 0;
    int strobeViolations = 0;

    div_sequencer #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .dividend_in(dividend_in),
        .divisor_in(divisor_in),
        .dp_data(dp_data),
        .dp_load_dividend(dp_load_dividend),
        .dp_load_divisor(dp_load_divisor),
        .dp_start(dp_start),
        .dp_enable(dp_enable),
        .dp_result(dp_result),
        .dp_residue(dp_residue),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: only yields the true result after exactly ITER enabled cycles.
    always @(posedge clk) begin
        if (dp_load_dividend) dpDvd <= dp_data;
        if (dp_load_divisor)  dpDvs <= dp_data;
        if (dp_start)         itCnt <= 0;
        else if (dp_enable)   itCnt <= itCnt + 1;
        enableTotal <= enableTotal + int'(dp_enable);
        startTotal  <= startTotal + int'(dp_start);
        if ($countones({dp_load_dividend, dp_load_divisor, dp_start, dp_enable}) > 1 ||
            (!dp_load_dividend && !dp_load_divisor && dp_data != '0))
            strobeViolations <= strobeViolations + 1;
    end

    always_comb begin
        dp_result  = 16'hBAD0;
        dp_residue = 16'hBAD1;
        if (itCnt == ITER && dpDvs != '0) begin
            dp_result  = dpDvd / dpDvs;
            dp_residue = dpDvd % dpDvs;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        else passes++;
    endtask

    // One complete transaction; holdCycles keeps rsp_ready low after rsp_valid rises.
    task automatic applyStimulus(input logic [15:0] dvd, input logic [15:0] dvs, input int holdCycles);
        logic [15:0] expQ, expR;
        logic        expZ;
        int          expLat, lat, n, e0, s0;
        expZ   = (dvs == 16'd0);
        expQ   = expZ ? 16'hFFFF : dvd / dvs;
        expR   = expZ ? dvd : dvd % dvs;
        expLat = expZ ? 3 : ITER + 5;

        @(negedge clk);
        req_valid   = 1'b1;
        dividend_in = dvd;
        divisor_in  = dvs;
        n = 0;
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n == 60) begin
            checkOutput("acceptTimeout", 32'd1, 32'd0);
            req_valid = 1'b0;
            return;
        end
        e0 = enableTotal;
        s0 = startTotal;
        @(posedge clk);
        #1;
        req_valid   = 1'($urandom_range(0, 1));
        dividend_in = 16'($urandom);
        divisor_in  = 16'($urandom);

        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 60);
        checkOutput("latency", lat, expLat);
        checkOutput("quotient", quotient, expQ);
        checkOutput("remainder", remainder, expR);
        checkOutput("divByZero", div_by_zero, expZ);
        checkOutput("enableCycles", enableTotal - e0, expZ ? 0 : ITER);
        checkOutput("startPulses", startTotal - s0, expZ ? 0 : 1);
        checkOutput("busyInResp", busy, 1'b1);

        req_valid = 1'b1;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("holdValid", rsp_valid, 1'b1);
            checkOutput("holdQuotient", quotient, expQ);
            checkOutput("holdRemainder", remainder, expR);
            checkOutput("holdReqReady", req_ready, 1'b0);
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("validDropped", rsp_valid, 1'b0);
        checkOutput("readyAfterResp", req_ready, 1'b1);
        checkOutput("idleAfterResp", busy, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e0, n, seen, edgeN, na, nh;
        int acc[2];
        int hs[2];
        logic [15:0] rq[2];
        logic [15:0] rr[2];

        rst = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        dividend_in = '0;
        divisor_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstReqReady", req_ready, 1'b1);
        checkOutput("rstBusy", busy, 1'b0);
        checkOutput("rstRspValid", rsp_valid, 1'b0);
        checkOutput("rstDpData", dp_data, 16'd0);
        checkOutput("rstQuotient", quotient, 16'd0);
        rst = 1'b0;

        applyStimulus(16'd100, 16'd7, 0);
        applyStimulus(16'h1234, 16'd0, 0);
        applyStimulus(16'd77, 16'd5, 10);
        applyStimulus(16'd5, 16'd9, 0);
        applyStimulus(16'hFFFF, 16'd1, 1);

        // Reset in the middle of RUN.
        @(negedge clk);
        req_valid = 1'b1;
        dividend_in = 16'd200;
        divisor_in = 16'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dp_enable && n < 20);
        checkOutput("runReached", dp_enable, 1'b1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midRunEnable", dp_enable, 1'b0);
        checkOutput("midRunReqReady", req_ready, 1'b1);
        checkOutput("midRunRspValid", rsp_valid, 1'b0);
        checkOutput("midRunBusy", busy, 1'b0);
        e0 = enableTotal;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checkOutput("noPartialResp", seen, 0);
        checkOutput("noEnableAfterRst", enableTotal - e0, 0);
        applyStimulus(16'd50, 16'd5, 0);

        // Back-to-back with rsp_ready tied high and req_valid held.
        edgeN = 0;
        na = 0;
        nh = 0;
        acc[0] = 0; acc[1] = 0; hs[0] = 0; hs[1] = 0;
        rq[0] = '0; rq[1] = '0; rr[0] = '0; rr[1] = '0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        dividend_in = 16'd9;
        divisor_in = 16'd3;
        for (int c = 0; c < 120 && nh < 2; c++) begin
            if (req_valid && req_ready && na < 2) begin
                acc[na] = edgeN + 1;
                na++;
            end
            if (rsp_valid && rsp_ready) begin
                hs[nh] = edgeN + 1;
                rq[nh] = quotient;
                rr[nh] = remainder;
                nh++;
            end
            @(posedge clk);
            edgeN++;
            #1;
            if (na == 1) begin
                dividend_in = 16'hFFFF;
                divisor_in = 16'h0010;
            end
            if (na == 2) req_valid = 1'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checkOutput("b2bResponses", nh, 2);
        checkOutput("b2bAccepts", na, 2);
        checkOutput("b2bQ0", rq[0], 16'd3);
        checkOutput("b2bR0", rr[0], 16'd0);
        checkOutput("b2bQ1", rq[1], 16'h0FFF);
        checkOutput("b2bR1", rr[1], 16'h000F);
        checkOutput("b2bFirstHandshake", hs[0] - acc[0], ITER + 6);
        checkOutput("b2bSecondAccept", acc[1] - hs[0], 1);

        for (int k = 0; k < 10; k++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 16'd0;
                1:       b = 16'($urandom_range(1, 20));
                default: b = 16'($urandom);
            endcase
            applyStimulus(a, b, $urandom_range(0, 3));
        end

        checkOutput("strobeExclusive", strobeViolations, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
